// File: rtl/multi_issue_decode_stage.sv
// Registered multi-lane decode stage: per-lane op decode, optional lane compaction,
// output register plus one-entry skid buffer behind a valid/ready handshake.

module lane_op_decoder #(
    parameter int INST_W  = 32,
    parameter int ALUOP_W = 8,
    parameter int SIGN_W  = 24
) (
    input  logic [INST_W-1:0]  inst_i,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic [SIGN_W-1:0]  sign_o
);
    logic [7:0] op;
    logic       is_imm;
    logic       imm_sext;

    // One-hot ALU function; 3R ops live under a zero top field, so no overlap with 2RI12.
    always_comb begin
        op       = '0;
        is_imm   = 1'b0;
        imm_sext = 1'b0;
        case (inst_i[31:15])
            17'h00020: op = 8'h01;
            17'h00022: op = 8'h02;
            17'h00024: op = 8'h04;
            17'h00025: op = 8'h08;
            17'h00028: op = 8'h10;
            17'h00029: op = 8'h20;
            17'h0002a: op = 8'h40;
            17'h0002b: op = 8'h80;
            default: begin
                is_imm = 1'b1;
                case (inst_i[31:22])
                    10'h00a: begin op = 8'h01; imm_sext = 1'b1; end
                    10'h008: begin op = 8'h04; imm_sext = 1'b1; end
                    10'h009: begin op = 8'h08; imm_sext = 1'b1; end
                    10'h00d: op = 8'h20;
                    10'h00e: op = 8'h40;
                    10'h00f: op = 8'h80;
                    default: is_imm = 1'b0;
                endcase
            end
        endcase
    end

    assign aluop_o = ALUOP_W'(op);
    assign sign_o  = (op != 8'h00) ? SIGN_W'({6'd0, is_imm, imm_sext, 1'b1, inst_i[14:0]}) : '0;
endmodule

module multi_issue_decode_stage #(
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 8,
    parameter int SIGN_W  = 24,
    parameter int COMPACT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ISSUE_W-1:0]        in_lane_v_i,
    input  logic [ISSUE_W*INST_W-1:0] in_inst_i,
    input  logic [ISSUE_W*PC_W-1:0]   in_pc_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ISSUE_W-1:0]        out_lane_v_o,
    output logic [ISSUE_W*PC_W-1:0]   out_pc_o,
    output logic [ISSUE_W*ALUOP_W-1:0] out_aluop_o,
    output logic [ISSUE_W*SIGN_W-1:0] out_sign_o,
    output logic [ISSUE_W-1:0]        out_ine_o,
    output logic [CNT_W-1:0]          decoded_cnt_o
);
    localparam int ALUOP_OFF = ISSUE_W * SIGN_W;
    localparam int PC_OFF    = ALUOP_OFF + ISSUE_W * ALUOP_W;
    localparam int INE_OFF   = PC_OFF + ISSUE_W * PC_W;
    localparam int LV_OFF    = INE_OFF + ISSUE_W;
    localparam int BUN_W     = LV_OFF + ISSUE_W;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;

    logic [ISSUE_W*ALUOP_W-1:0] raw_aluop;
    logic [ISSUE_W*SIGN_W-1:0]  raw_sign;

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        lane_op_decoder #(.INST_W(INST_W), .ALUOP_W(ALUOP_W), .SIGN_W(SIGN_W)) u_dec (
            .inst_i  (in_inst_i[g*INST_W +: INST_W]),
            .aluop_o (raw_aluop[g*ALUOP_W +: ALUOP_W]),
            .sign_o  (raw_sign[g*SIGN_W +: SIGN_W])
        );
    end

    logic [ISSUE_W-1:0]         dec_v;
    logic [ISSUE_W-1:0]         dec_ine;
    logic [ISSUE_W*PC_W-1:0]    dec_pc;
    logic [ISSUE_W*ALUOP_W-1:0] dec_aluop;
    logic [ISSUE_W*SIGN_W-1:0]  dec_sign;
    logic [BUN_W-1:0]           dec_bundle;
    int                         slot;
    int                         dst;

    // Invalid lanes stay zero; with COMPACT the k-th valid lane lands in slot k.
    always_comb begin
        dec_v     = '0;
        dec_ine   = '0;
        dec_pc    = '0;
        dec_aluop = '0;
        dec_sign  = '0;
        slot      = 0;
        dst       = 0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (in_lane_v_i[i]) begin
                dst = (COMPACT != 0) ? slot : i;
                dec_v[dst]   = 1'b1;
                dec_ine[dst] = (raw_aluop[i*ALUOP_W +: ALUOP_W] == '0) &&
                               (raw_sign[i*SIGN_W +: SIGN_W] == '0);
                dec_pc[dst*PC_W +: PC_W]          = in_pc_i[i*PC_W +: PC_W];
                dec_aluop[dst*ALUOP_W +: ALUOP_W] = raw_aluop[i*ALUOP_W +: ALUOP_W];
                dec_sign[dst*SIGN_W +: SIGN_W]    = raw_sign[i*SIGN_W +: SIGN_W];
                slot = slot + 1;
            end
        end
    end

    assign dec_bundle = {dec_v, dec_ine, dec_pc, dec_aluop, dec_sign};

    function automatic logic [CNT_W-1:0] lane_popcount(input logic [ISSUE_W-1:0] v);
        lane_popcount = '0;
        for (int i = 0; i < ISSUE_W; i++) lane_popcount = lane_popcount + CNT_W'(v[i]);
    endfunction

    state_e           state_q, state_d;
    logic [BUN_W-1:0] or_q, or_d;
    logic [BUN_W-1:0] sk_q, sk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_take;
    logic             out_xfer;

    // Handshake: a beat moves on a side when its valid and ready are both high at the
    // rising edge; in_ready_o comes only from the state flop (it drops once the skid is full).
    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_take     = in_valid_i & in_ready_o & (|in_lane_v_i);
    assign out_xfer    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            or_d    = '0;
            sk_d    = '0;
        end else begin
            if (out_xfer) cnt_d = cnt_q + lane_popcount(or_q[LV_OFF +: ISSUE_W]);
            case (state_q)
                ST_EMPTY: if (in_take) begin state_d = ST_ONE; or_d = dec_bundle; end
                ST_ONE: begin
                    if (in_take && out_xfer) or_d = dec_bundle;
                    else if (in_take) begin state_d = ST_TWO; sk_d = dec_bundle; end
                    else if (out_xfer) begin state_d = ST_EMPTY; or_d = '0; end
                end
                ST_TWO: if (out_xfer) begin state_d = ST_ONE; or_d = sk_q; sk_d = '0; end
                default: begin state_d = ST_EMPTY; or_d = '0; sk_d = '0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            or_q    <= '0;
            sk_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sk_q    <= sk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_lane_v_o  = or_q[LV_OFF +: ISSUE_W];
    assign out_ine_o     = or_q[INE_OFF +: ISSUE_W];
    assign out_pc_o      = or_q[PC_OFF +: ISSUE_W*PC_W];
    assign out_aluop_o   = or_q[ALUOP_OFF +: ISSUE_W*ALUOP_W];
    assign out_sign_o    = or_q[0 +: ISSUE_W*SIGN_W];
    assign decoded_cnt_o = cnt_q;
endmodule

// File: tb/tb_multi_issue_decode_stage.sv
// Randomized bench for multi_issue_decode_stage: two instances (compacting and positional)
// share stimulus and are compared every cycle against a two-deep FIFO reference model.

module tb_multi_issue_decode_stage;
    localparam logic [16:0] OP3R [8] = '{17'h00020, 17'h00022, 17'h00024, 17'h00025,
                                         17'h00028, 17'h00029, 17'h0002a, 17'h0002b};
    localparam logic [9:0]  OPI [6]      = '{10'h00a, 10'h008, 10'h009, 10'h00d, 10'h00e, 10'h00f};
    localparam int          OPI_BIT [6]  = '{0, 2, 3, 5, 6, 7};
    localparam logic        OPI_SEXT [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_lane_v;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready_c, out_valid_c, in_ready_n, out_valid_n;
    logic [1:0]  lv_c, ine_c, lv_n, ine_n;
    logic [63:0] pc_c, pc_n;
    logic [15:0] aluop_c, aluop_n;
    logic [47:0] sign_c, sign_n;
    logic [3:0]  cnt_c, cnt_n;

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_cnt;
    int         tests;
    int         fails;

    multi_issue_decode_stage #(.ISSUE_W(2), .COMPACT(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_c),
        .in_lane_v_i(in_lane_v), .in_inst_i(in_inst), .in_pc_i(in_pc), .out_valid_o(out_valid_c),
        .out_ready_i(out_ready), .out_lane_v_o(lv_c), .out_pc_o(pc_c), .out_aluop_o(aluop_c),
        .out_sign_o(sign_c), .out_ine_o(ine_c), .decoded_cnt_o(cnt_c)
    );

    multi_issue_decode_stage #(.ISSUE_W(2), .COMPACT(0), .CNT_W(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_n),
        .in_lane_v_i(in_lane_v), .in_inst_i(in_inst), .in_pc_i(in_pc), .out_valid_o(out_valid_n),
        .out_ready_i(out_ready), .out_lane_v_o(lv_n), .out_pc_o(pc_n), .out_aluop_o(aluop_n),
        .out_sign_o(sign_n), .out_ine_o(ine_n), .decoded_cnt_o(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Table-driven reference decode of the supported LoongArch subset.
    function automatic void ref_decode(input logic [31:0] inst, output logic [7:0] aluop,
                                       output logic [23:0] sign);
        aluop = '0;
        sign  = '0;
        for (int t = 0; t < 8; t++)
            if (inst[31:15] == OP3R[t]) begin
                aluop = 8'(1 << t);
                sign  = {6'd0, 1'b0, 1'b0, 1'b1, inst[14:0]};
            end
        for (int t = 0; t < 6; t++)
            if (inst[31:22] == OPI[t]) begin
                aluop = 8'(1 << OPI_BIT[t]);
                sign  = {6'd0, 1'b1, OPI_SEXT[t], 1'b1, inst[14:0]};
            end
    endfunction

    task automatic model_out(input exp_t e, input bit compact, output logic [1:0] lv,
                             output logic [1:0] ine, output logic [63:0] pc,
                             output logic [15:0] aluop, output logic [47:0] sign);
        int          src_q[$];
        int          d;
        logic [7:0]  a;
        logic [23:0] s;
        lv = '0; ine = '0; pc = '0; aluop = '0; sign = '0;
        for (int i = 0; i < 2; i++) if (e.lv[i]) src_q.push_back(i);
        foreach (src_q[p]) begin
            d = compact ? p : src_q[p];
            ref_decode(e.inst[src_q[p]*32 +: 32], a, s);
            lv[d]             = 1'b1;
            ine[d]            = (a == 0) && (s == 0);
            pc[d*32 +: 32]    = e.pc[src_q[p]*32 +: 32];
            aluop[d*8 +: 8]   = a;
            sign[d*24 +: 24]  = s;
        end
    endtask

    task automatic check_all();
        logic [1:0]  lv, ine;
        logic [63:0] pc;
        logic [15:0] al;
        logic [47:0] sg;
        check("c_out_valid", out_valid_c, exp_q.size() > 0);
        check("n_out_valid", out_valid_n, exp_q.size() > 0);
        check("c_in_ready", in_ready_c, exp_q.size() < 2);
        check("n_in_ready", in_ready_n, exp_q.size() < 2);
        check("c_cnt", cnt_c, exp_cnt);
        check("n_cnt", cnt_n, exp_cnt);
        if (exp_q.size() > 0) begin
            model_out(exp_q[0], 1'b1, lv, ine, pc, al, sg);
            check("c_lane_v", lv_c, lv);
            check("c_ine", ine_c, ine);
            check("c_pc", pc_c, pc);
            check("c_aluop", aluop_c, al);
            check("c_sign", sign_c, sg);
            model_out(exp_q[0], 1'b0, lv, ine, pc, al, sg);
            check("n_lane_v", lv_n, lv);
            check("n_ine", ine_n, ine);
            check("n_pc", pc_n, pc);
            check("n_aluop", aluop_n, al);
            check("n_sign", sign_n, sg);
        end
    endtask

    // One clock: decide transfers from pre-edge model state, apply them, check at negedge.
    task automatic step();
        bit   in_x, out_x;
        exp_t e;
        in_x   = in_valid && (exp_q.size() < 2);
        out_x  = (exp_q.size() > 0) && out_ready;
        e.lv   = in_lane_v;
        e.inst = in_inst;
        e.pc   = in_pc;
        @(posedge clk);
        if (flush) exp_q.delete();
        else begin
            if (out_x) begin
                exp_cnt += 4'($countones(exp_q[0].lv));
                void'(exp_q.pop_front());
            end
            if (in_x && e.lv != 2'b00) exp_q.push_back(e);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic [1:0] lv, input logic [63:0] inst, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_lane_v = lv;
        in_inst   = inst;
        in_pc     = pc;
    endtask

    // Asserts reset between clock edges and checks the outputs before the next edge.
    task automatic async_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cnt = '0;
        check("rst_valid", out_valid_c, 0);
        check("rst_lane_v", lv_c, 0);
        check("rst_ine", ine_c, 0);
        check("rst_pc", pc_c, 0);
        check("rst_aluop", aluop_c, 0);
        check("rst_sign", sign_c, 0);
        check("rst_cnt", cnt_c, 0);
        check("rst_n_valid", out_valid_n, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return $urandom;
        if (r == 1) return {OP3R[$urandom_range(0, 7)], 15'($urandom)};
        return {OPI[$urandom_range(0, 5)], 22'($urandom)};
    endfunction

    initial begin
        logic [3:0] cnt_before;
        tests = 0; fails = 0; exp_cnt = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane_v = '0;
        in_inst = '0; in_pc = '0; out_ready = 1'b0;
        async_reset();

        // add.w r1,r2,r3 in lane 0, all-zero word in lane 1
        out_ready = 1'b1;
        drive(2'b11, {32'h00000000, 32'h00100C41}, {32'h1C000004, 32'h1C000000});
        step();
        check("dir_valid", out_valid_c, 1);
        check("dir_ine", ine_c, 2'b10);
        check("dir_aluop0", aluop_c[7:0], 8'h01);
        in_valid = 1'b0;
        step();
        check("dir_cnt", cnt_c, 2);

        // backpressure: A in output register, B in skid
        out_ready = 1'b0;
        drive(2'b01, {32'h0, 32'h00148c41}, {32'h0, 32'h1C000100});
        step();
        drive(2'b11, {32'h03800421, 32'h02bffc41}, {32'h1C000204, 32'h1C000200});
        step();
        check("bp_in_ready", in_ready_c, 0);
        in_valid = 1'b0;
        repeat (3) step();
        check("bp_pc_a", pc_c[31:0], 32'h1C000100);
        out_ready = 1'b1;
        step();
        check("bp_ready_after", in_ready_c, 1);
        check("bp_pc_b", pc_c[31:0], 32'h1C000200);
        step();

        // compaction of a lone upper lane
        drive(2'b10, {32'h02800421, 32'h00100C41}, {32'h1C000004, 32'h1C000000});
        step();
        check("cmp_lv_c", lv_c, 2'b01);
        check("cmp_pc0_c", pc_c[31:0], 32'h1C000004);
        check("cmp_lv_n", lv_n, 2'b10);
        in_valid = 1'b0;
        step();

        // flush while two bundles held, with simultaneous input and output transfer
        out_ready = 1'b0;
        drive(2'b11, {32'h00100C41, 32'h00100C41}, {32'h1C000304, 32'h1C000300});
        step();
        drive(2'b01, {32'h0, 32'h00100C41}, {32'h0, 32'h1C000400});
        step();
        cnt_before = exp_cnt;
        flush = 1'b1; out_ready = 1'b1;
        drive(2'b11, {32'h00100C41, 32'h00100C41}, {32'h1C000504, 32'h1C000500});
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid_c, 0);
        check("fl_ready", in_ready_c, 1);
        check("fl_cnt", cnt_c, cnt_before);

        // counter wrap with a 4-bit counter
        async_reset();
        out_ready = 1'b1;
        repeat (7) begin
            drive(2'b11, {rand_inst(), rand_inst()}, {32'($urandom), 32'($urandom)});
            step();
        end
        in_valid = 1'b0;
        step();
        check("wrap_14", cnt_c, 14);
        drive(2'b11, {rand_inst(), rand_inst()}, {32'($urandom), 32'($urandom)});
        step();
        in_valid = 1'b0;
        step();
        check("wrap_0", cnt_c, 0);

        // asynchronous reset during a stall, then first bundle latency
        out_ready = 1'b0;
        drive(2'b11, {rand_inst(), rand_inst()}, {32'($urandom), 32'($urandom)});
        step();
        drive(2'b01, {rand_inst(), rand_inst()}, {32'($urandom), 32'($urandom)});
        step();
        async_reset();
        out_ready = 1'b1;
        drive(2'b01, {32'h0, 32'h00100C41}, {32'h0, 32'h1C000600});
        step();
        check("rst_lat_valid", out_valid_c, 1);
        check("rst_lat_pc", pc_c[31:0], 32'h1C000600);
        in_valid = 1'b0;
        step();

        // randomized traffic
        repeat (500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_lane_v = 2'($urandom_range(0, 3));
            in_inst   = {rand_inst(), rand_inst()};
            in_pc     = {32'($urandom), 32'($urandom)};
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
